hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS datapath, sitting beside the forwarding unit.
//  Covers the hazards forwarding cannot resolve:
//  - load-use stall;
//  - multi-cycle mult/div occupancy of EX;
//  - taken-branch flush.
//  Drives the PC, IF/ID, ID/EX and EX/MEM write-enable and bubble controls.
// PARAMETERS
//  MD_LATENCY  4   cycles a mult/div occupies EX (legal range 1..15; 1 = no extra stall)
//  STAT_W      16  width of stall/flush counters (HAZARD_STATS_EN only)
// PORTS
//  CLOCK          in   1   pipeline clock; all state updates on posedge
//  RESET          in   1   synchronous, active-high reset
//  IFID_Rs        in   5   rs field of the instruction in ID
//  IFID_Rt        in   5   rt field of the instruction in ID
//  IFID_UsesRt    in   1   ID instruction reads rt as a source
//  IDEX_Rt        in   5   destination rt of the instruction in EX
//  IDEX_MemRead   in   1   instruction in EX is a load
//  ID_MultDiv     in   1   instruction in ID is mult/div
//  EX_BranchTaken in   1   branch/jump in EX resolved taken
//  PC_Write       out  1   PC update enable
//  IFID_Write     out  1   IF/ID register enable
//  IFID_Flush     out  1   IF/ID is cleared to NOP on this edge
//  IDEX_Write     out  1   ID/EX register enable
//  IDEX_Bubble    out  1   ID/EX is loaded with control-zero (NOP) on this edge
//  EXMEM_Bubble   out  1   EX/MEM is loaded with NOP on this edge
//  MD_Busy        out  1   mult/div is holding EX
// BEHAVIOUR
//  - FSM states: RUN, MD_BUSY. A 4-bit cycle counter md_cnt is held in a register.
//  - Outputs are combinational from the state and inputs, and are sampled by the datapath at the next posedge.
//  - While RESET=1: PC_Write=0, IFID_Write=0, IDEX_Write=1, IDEX_Bubble=1, IFID_Flush=0, EXMEM_Bubble=0, MD_Busy=0.
//  - At the reset edge: state<=RUN, md_cnt<=0.
//  - Defaults in RUN: PC_Write=1, IFID_Write=1, IDEX_Write=1, all bubble/flush outputs 0, MD_Busy=0.
//  - Load-use hazard (lu) is true when all of the following hold:
//    - IDEX_MemRead=1;
//    - IDEX_Rt!=0;
//    - IDEX_Rt==IFID_Rs, or (IFID_UsesRt=1 and IDEX_Rt==IFID_Rt).
//  - RUN priority, highest first:
//    1. EX_BranchTaken: PC_Write=1, IFID_Flush=1, IDEX_Bubble=1. lu and ID_MultDiv are ignored (wrong path); state stays RUN.
//    2. lu: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle; state stays RUN. ID_MultDiv is ignored this cycle.
//    3. ID_MultDiv with MD_LATENCY>1: normal advance. At the edge, state<=MD_BUSY and md_cnt<=MD_LATENCY-1.
//  - In MD_BUSY:
//    - Outputs: PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, MD_Busy=1.
//    - lu and EX_BranchTaken are ignored (EX holds the mult/div, so no branch can be resolving).
//    - md_cnt decrements each cycle. When md_cnt==1, next state is RUN.
//    - Net effect: the mult/div sits in EX for MD_LATENCY cycles (MD_LATENCY-1 stall cycles). Its final EX cycle is a RUN cycle.
//  - Back-to-back mult/div: a second ID_MultDiv seen in the first RUN cycle after MD_BUSY re-enters MD_BUSY with a full count.
//  - RESET asserted mid-MD_BUSY: the reset values apply that cycle, then RUN. The counter is discarded.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds three outputs, each STAT_W wide, reset to 0 and saturating at all-ones:
//    - Load_Stalls: +1 per lu stall cycle;
//    - MD_Stalls: +1 per MD_BUSY cycle;
//    - Flushes: +1 per taken-branch cycle.
//  HAZARD_STATS_EN undefined: these ports and their counters do not exist. All other behaviour is identical.
// TESTING
//  1. RESET=1 for 2 cycles, then 0 -> outputs equal the reset values during reset, then the RUN defaults (PC_Write=1, IFID_Write=1).
//  2. Load-use stall:
//     - Stimulus: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for 1 cycle.
//     - Required: PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for that cycle.
//     - Repeat with IDEX_Rt=0, then with IFID_Rt=8 and IFID_UsesRt=0 -> no stall.
//  3. Mult/div, MD_LATENCY=4:
//     - Stimulus: ID_MultDiv=1 at cycle T.
//     - Required in cycles T+1..T+3: MD_Busy=1, PC_Write=0, IDEX_Write=0, EXMEM_Bubble=1.
//     - Required at T+4: RUN defaults.
//     - With MD_LATENCY=1: MD_Busy never asserts.
//  4. Taken branch with simultaneous lu and ID_MultDiv -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; no MD_BUSY entry.
//  5. RESET at T+2 of test 3 -> next cycle MD_Busy=0, RUN defaults. A following ID_MultDiv gives a full 3-cycle stall.
//  6. HAZARD_STATS_EN, STAT_W=2:
//     - 5 lu stalls -> Load_Stalls saturates at 3.
//     - Test 3 sequence -> MD_Stalls=3.
//     - RESET -> all counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline sequencing controller for a 5-stage MIPS datapath. It works next to
// the forwarding unit and handles the hazards that forwarding cannot resolve:
//   - load-use stall (one bubble into ID/EX, PC and IF/ID held)
//   - multi-cycle mult/div occupying EX (front end frozen, EX/MEM bubbled)
//   - taken-branch flush (IF/ID cleared, ID/EX bubbled)
//
// Outputs are combinational from the state and the inputs. The datapath
// samples them at the next posedge.
//
// Parameters
//   MD_LATENCY  cycles a mult/div occupies EX (1..15, 1 = no extra stall)
//   STAT_W      width of the stall/flush counters (statistics build only)
//
// Ports
//   CLOCK, RESET     clock, synchronous active-high reset
//   IFID_Rs/Rt       source fields of the instruction in ID
//   IFID_UsesRt      ID instruction reads rt
//   IDEX_Rt          destination rt of the instruction in EX
//   IDEX_MemRead     EX instruction is a load
//   ID_MultDiv       ID instruction is mult/div
//   EX_BranchTaken   branch/jump in EX resolved taken
//   PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
//   EXMEM_Bubble, MD_Busy   pipeline register controls / status
//
// Optional feature: define HAZARD_STATS_EN to add three saturating counters
// (Load_Stalls, MD_Stalls, Flushes), each STAT_W bits wide.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int STAT_W     = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic [4:0] IDEX_Rt,
    input  logic       IDEX_MemRead,
    input  logic       ID_MultDiv,
    input  logic       EX_BranchTaken,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Write,
    output logic       IDEX_Bubble,
    output logic       EXMEM_Bubble,
    output logic       MD_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] Load_Stalls,
    output logic [STAT_W-1:0] MD_Stalls,
    output logic [STAT_W-1:0] Flushes
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);
    localparam bit         MD_STALLS = (MD_LATENCY > 1);

    state_e     state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       lu;

    // r0 is hardwired to zero, so a load "into r0" never creates a dependency.
    assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MD_Busy      = 1'b0;
        if (RESET) begin
            // Front end frozen, ID/EX filled with NOPs while in reset.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (EX_BranchTaken) begin
                        // ID holds a wrong-path instruction: its hazards are moot.
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (lu) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end else if (ID_MultDiv && MD_STALLS) begin
                        // Mult/div advances into EX normally, then holds it.
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    PC_Write     = 1'b0;
                    IFID_Write   = 1'b0;
                    IDEX_Write   = 1'b0;
                    EXMEM_Bubble = 1'b1;
                    MD_Busy      = 1'b1;
                    md_cnt_d     = md_cnt_q - 4'd1;
                    // Last EX cycle of the mult/div is spent back in RUN.
                    if (md_cnt_q <= 4'd1) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic lu_stall, md_cyc, br_cyc;
    logic [STAT_W-1:0] ld_q, md_q, fl_q;

    assign br_cyc   = !RESET && (state_q == RUN) && EX_BranchTaken;
    assign lu_stall = !RESET && (state_q == RUN) && !EX_BranchTaken && lu;
    assign md_cyc   = !RESET && (state_q == MD_BUSY);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ld_q <= '0;
            md_q <= '0;
            fl_q <= '0;
        end else begin
            if (lu_stall && (ld_q != '1)) ld_q <= ld_q + 1'b1;
            if (md_cyc   && (md_q != '1)) md_q <= md_q + 1'b1;
            if (br_cyc   && (fl_q != '1)) fl_q <= fl_q + 1'b1;
        end
    end

    assign Load_Stalls = ld_q;
    assign MD_Stalls   = md_q;
    assign Flushes     = fl_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: the driver applies one input vector per cycle and pushes
// the hand-computed expected output vector; the monitor pops one entry per
// cycle at the falling edge and compares. Two instances run side by side,
// MD_LATENCY=4 and MD_LATENCY=1, on the same inputs.
module tb_hazard_stall_ctrl;

    localparam int STAT_W = 2;

    // Expected vector: {PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
    //                   IDEX_Bubble, EXMEM_Bubble, MD_Busy}
    localparam logic [6:0] V_RUN = 7'b1101000;
    localparam logic [6:0] V_LU  = 7'b0001100;
    localparam logic [6:0] V_RST = 7'b0001100;
    localparam logic [6:0] V_BR  = 7'b1111100;
    localparam logic [6:0] V_MD  = 7'b0000011;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
    logic       IFID_UsesRt = 1'b0, IDEX_MemRead = 1'b0;
    logic       ID_MultDiv = 1'b0, EX_BranchTaken = 1'b0;

    logic pcw4, ifw4, iff4, idw4, idb4, exb4, mdb4;
    logic pcw1, ifw1, iff1, idw1, idb1, exb1, mdb1;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] ls4, ms4, fl4, ls1, ms1, fl1;
`endif

    always #5 CLOCK = ~CLOCK;

    hazard_stall_ctrl #(.MD_LATENCY(4), .STAT_W(STAT_W)) dut4 (
        .CLOCK(CLOCK), .RESET(RESET), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
        .ID_MultDiv(ID_MultDiv), .EX_BranchTaken(EX_BranchTaken),
        .PC_Write(pcw4), .IFID_Write(ifw4), .IFID_Flush(iff4), .IDEX_Write(idw4),
        .IDEX_Bubble(idb4), .EXMEM_Bubble(exb4), .MD_Busy(mdb4)
`ifdef HAZARD_STATS_EN
        , .Load_Stalls(ls4), .MD_Stalls(ms4), .Flushes(fl4)
`endif
    );

    hazard_stall_ctrl #(.MD_LATENCY(1), .STAT_W(STAT_W)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
        .ID_MultDiv(ID_MultDiv), .EX_BranchTaken(EX_BranchTaken),
        .PC_Write(pcw1), .IFID_Write(ifw1), .IFID_Flush(iff1), .IDEX_Write(idw1),
        .IDEX_Bubble(idb1), .EXMEM_Bubble(exb1), .MD_Busy(mdb1)
`ifdef HAZARD_STATS_EN
        , .Load_Stalls(ls1), .MD_Stalls(ms1), .Flushes(fl1)
`endif
    );

    typedef struct {
        string       nm;
        logic [6:0]  e4;
        logic [6:0]  e1;
        bit          cs;
        logic [1:0]  ls;
        logic [1:0]  ms;
        logic [1:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Stats expectations carried with the next step (cs=1 means check them).
    bit         st_cs = 1'b0;
    logic [1:0] st_ls = '0, st_ms = '0, st_fl = '0;

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic usesrt, input logic [4:0] exrt, input logic memrd,
                        input logic md, input logic br,
                        input logic [6:0] e4, input logic [6:0] e1, input string nm);
        exp_t e;
        @(posedge CLOCK);
        #1;
        RESET = rst; IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = usesrt;
        IDEX_Rt = exrt; IDEX_MemRead = memrd; ID_MultDiv = md; EX_BranchTaken = br;
        e.nm = nm; e.e4 = e4; e.e1 = e1;
        e.cs = st_cs; e.ls = st_ls; e.ms = st_ms; e.fl = st_fl;
        st_cs = 1'b0;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [6:0] e4, input logic [6:0] e1, input string nm);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e4, e1, nm);
    endtask

    task automatic stats(input logic [1:0] l, input logic [1:0] m, input logic [1:0] f);
        st_cs = 1'b1; st_ls = l; st_ms = m; st_fl = f;
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        logic [6:0] a4, a1;
        forever begin
            @(negedge CLOCK);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                a4 = {pcw4, ifw4, iff4, idw4, idb4, exb4, mdb4};
                a1 = {pcw1, ifw1, iff1, idw1, idb1, exb1, mdb1};
                checks++;
                if (a4 !== e.e4) begin
                    failures++;
                    $display("FAIL %s lat4 got=%b exp=%b", e.nm, a4, e.e4);
                end
                checks++;
                if (a1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s lat1 got=%b exp=%b", e.nm, a1, e.e1);
                end
`ifdef HAZARD_STATS_EN
                if (e.cs) begin
                    checks++;
                    if ({ls4, ms4, fl4} !== {e.ls, e.ms, e.fl}) begin
                        failures++;
                        $display("FAIL %s stats got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                 e.nm, ls4, ms4, fl4, e.ls, e.ms, e.fl);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST, V_RST, "rst0");
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST, V_RST, "rst1");
        idle(V_RUN, V_RUN, "run_after_rst");

        // Load-use
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, V_LU, V_LU, "lu_rs");
        idle(V_RUN, V_RUN, "lu_release");
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, V_RUN, V_RUN, "lu_r0");
        step(1'b0, 5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, V_RUN, V_RUN, "lu_rt_unused");
        step(1'b0, 5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, V_LU, V_LU, "lu_rt_used");
        step(1'b0, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN, "no_load");
        // lu takes priority over a mult/div in ID: no MD_BUSY entry
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, V_LU, V_LU, "lu_over_md");
        idle(V_RUN, V_RUN, "lu_over_md_next");

        // Mult/div; branch+lu inside MD_BUSY are ignored by the latency-4 unit
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_RUN, V_RUN, "md_T");
        idle(V_MD, V_RUN, "md_T1");
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, V_MD, V_BR, "md_T2_ign");
        idle(V_MD, V_RUN, "md_T3");
        idle(V_RUN, V_RUN, "md_T4");

        // Back-to-back mult/div
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_RUN, V_RUN, "b2b_T");
        idle(V_MD, V_RUN, "b2b_T1");
        idle(V_MD, V_RUN, "b2b_T2");
        idle(V_MD, V_RUN, "b2b_T3");
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_RUN, V_RUN, "b2b_T4_md");
        idle(V_MD, V_RUN, "b2b_T5");
        idle(V_MD, V_RUN, "b2b_T6");
        idle(V_MD, V_RUN, "b2b_T7");
        idle(V_RUN, V_RUN, "b2b_T8");

        // Taken branch beats lu and mult/div
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, V_BR, V_BR, "br_all");
        idle(V_RUN, V_RUN, "br_no_md");

        // Reset in the middle of MD_BUSY
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_RUN, V_RUN, "mdr_T");
        idle(V_MD, V_RUN, "mdr_T1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST, V_RST, "mdr_T2_rst");
        stats(2'd0, 2'd0, 2'd0);
        idle(V_RUN, V_RUN, "mdr_T3");
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_RUN, V_RUN, "mdr2_T");
        idle(V_MD, V_RUN, "mdr2_T1");
        idle(V_MD, V_RUN, "mdr2_T2");
        idle(V_MD, V_RUN, "mdr2_T3");
        stats(2'd0, 2'd3, 2'd0);
        idle(V_RUN, V_RUN, "mdr2_T4");

        // Five load-use stalls: counter saturates at 3 with STAT_W=2
        for (int i = 0; i < 5; i++)
            step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, V_LU, V_LU, "lu_sat");
        stats(2'd3, 2'd3, 2'd0);
        idle(V_RUN, V_RUN, "lu_sat_chk");
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, V_BR, V_BR, "br_cnt");
        stats(2'd3, 2'd3, 2'd1);
        idle(V_RUN, V_RUN, "br_cnt_chk");
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST, V_RST, "rst_stats");
        stats(2'd0, 2'd0, 2'd0);
        idle(V_RUN, V_RUN, "stats_cleared");

        repeat (3) @(posedge CLOCK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
